// File: rtl/chip8_loader.sv
// CHIP-8 program loader: parses SYNC/LEN/payload/CSUM frames from a byte stream, writes the
// payload into program memory at BASE_ADDR and releases the CPU once the checksum matches.
module chip8_loader #(
    parameter int unsigned BASE_ADDR = 'h100,
    parameter int unsigned MEM_SIZE  = 4096,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        restart,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] MAX_LEN = 16'(MEM_SIZE - BASE_ADDR);
    localparam logic [11:0] BASE    = 12'(BASE_ADDR);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLenHi = 3'd1;
    localparam logic [2:0] StLenLo = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StCsum  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;
    localparam logic [2:0] StError = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        accept;

    // Ready depends only on state and restart, never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (!restart) begin
            case (state_q)
                StIdle, StLenHi, StLenLo, StData, StCsum: in_ready = 1'b1;
                default:                                  in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (restart) begin
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && in_data == SYNC_BYTE) state_d = StLenHi;
                end
                StLenHi: begin
                    if (accept) begin
                        len_d   = {in_data, 8'h00};
                        state_d = StLenLo;
                    end
                end
                StLenLo: begin
                    if (accept) begin
                        len_d = {len_q[15:8], in_data};
                        idx_d = '0;
                        sum_d = '0;
                        if (len_d > MAX_LEN)    state_d = StError;
                        else if (len_d == '0)   state_d = StCsum;
                        else                    state_d = StData;
                    end
                end
                StData: begin
                    if (accept) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE + idx_q[11:0];
                        mem_wdata_d = in_data;
                        sum_d       = sum_q + in_data;
                        idx_d       = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1) state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (accept) state_d = (in_data == sum_q) ? StDone : StError;
                end
                StDone, StError: state_d = state_q;
                default:         state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = (state_q == StDone);
    assign error     = (state_q == StError);
    assign cpu_hold  = (state_q != StDone);

endmodule

// File: tb/tb_chip8_loader.sv
// Directed self-checking bench for chip8_loader: one task per scenario, hand-computed values.
module tb_chip8_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int nchecks = 0;
    int nerrors = 0;
    int cyc = 0;

    logic [11:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];

    chip8_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every observed memory write with the cycle it was seen in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        nchecks++;
        if (in_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL send_ready byte=%02h: in_ready=%b expected 1", b, in_ready);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Stop driving and settle just after the next falling edge.
    task automatic finish_in();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic do_restart();
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b1;
        #1;
        nchecks++;
        if (in_ready !== 1'b0) begin
            nerrors++;
            $display("FAIL restart_ready: in_ready=%b expected 0", in_ready);
        end
        @(negedge clk);
        restart = 1'b0;
        #1;
        clear_log();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        nchecks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !==
            {1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            nerrors++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b expected 1 0 000 00 1 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
        end
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        clear_log();
    endtask

    task automatic test_nominal();
        logic [11:0] ea[3];
        logic [7:0]  ed[3];
        ea = '{12'h100, 12'h101, 12'h102};
        ed = '{8'h12, 8'h34, 8'h56};
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h12); send(8'h34); send(8'h56); send(8'h9C);
        #1;
        nchecks++;
        if (done !== 1'b0) begin
            nerrors++;
            $display("FAIL nominal_done_early: done=%b expected 0", done);
        end
        finish_in();
        nchecks++;
        if (wa_q.size() != 3) begin
            nerrors++;
            $display("FAIL nominal_nwrites: got %0d expected 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nchecks++;
                if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                    nerrors++;
                    $display("FAIL nominal_write%0d: %h=%h expected %h=%h",
                             i, wa_q[i], wd_q[i], ea[i], ed[i]);
                end
            end
            nchecks++;
            if (wc_q[1] != wc_q[0] + 1 || wc_q[2] != wc_q[1] + 1) begin
                nerrors++;
                $display("FAIL nominal_consecutive: cycles %0d %0d %0d expected consecutive",
                         wc_q[0], wc_q[1], wc_q[2]);
            end
            nchecks++;
            if (cyc != wc_q[2] + 1) begin
                nerrors++;
                $display("FAIL nominal_done_latency: done at %0d last write %0d expected +1",
                         cyc, wc_q[2]);
            end
        end
        nchecks++;
        if ({done, error, cpu_hold, in_ready, mem_we} !== 5'b10000) begin
            nerrors++;
            $display("FAIL nominal_status: done=%b err=%b hold=%b rdy=%b we=%b expected 1 0 0 0 0",
                     done, error, cpu_hold, in_ready, mem_we);
        end
    endtask

    task automatic test_bad_csum();
        do_restart();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h01); send(8'h02); send(8'h04);
        finish_in();
        nchecks++;
        if (wa_q.size() != 2) begin
            nerrors++;
            $display("FAIL badcsum_nwrites: got %0d expected 2", wa_q.size());
        end
        nchecks++;
        if ({error, done, cpu_hold, in_ready} !== 4'b1010) begin
            nerrors++;
            $display("FAIL badcsum_status: err=%b done=%b hold=%b rdy=%b expected 1 0 1 0",
                     error, done, cpu_hold, in_ready);
        end
        // ERROR is sticky and ignores further traffic.
        @(negedge clk); in_data = 8'hA5; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h00;
        finish_in();
        nchecks++;
        if (error !== 1'b1 || wa_q.size() != 2) begin
            nerrors++;
            $display("FAIL badcsum_sticky: err=%b nwrites=%0d expected 1 2", error, wa_q.size());
        end
    endtask

    task automatic test_oversize();
        do_restart();
        send(8'hA5); send(8'h0F); send(8'h01);
        finish_in();
        nchecks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            nerrors++;
            $display("FAIL oversize_status: err=%b done=%b hold=%b expected 1 0 1",
                     error, done, cpu_hold);
        end
        gap(3);
        #1;
        nchecks++;
        if (wa_q.size() != 0) begin
            nerrors++;
            $display("FAIL oversize_nwrites: got %0d expected 0", wa_q.size());
        end
    endtask

    task automatic test_max_len_boundary();
        // 3840 is exactly MAX_LEN: must enter DATA, not ERROR.
        do_restart();
        send(8'hA5); send(8'h0F); send(8'h00);
        send(8'h01);
        finish_in();
        nchecks++;
        if (error !== 1'b0 || wa_q.size() != 1) begin
            nerrors++;
            $display("FAIL maxlen_accept: err=%b nwrites=%0d expected 0 1", error, wa_q.size());
        end
    endtask

    task automatic test_zero_len();
        do_restart();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        finish_in();
        nchecks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || wa_q.size() != 0) begin
            nerrors++;
            $display("FAIL zerolen: done=%b err=%b hold=%b nwrites=%0d expected 1 0 0 0",
                     done, error, cpu_hold, wa_q.size());
        end
    endtask

    task automatic test_framing_gaps();
        logic [7:0] seq[7];
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hAA, 8'hAA};
        do_restart();
        for (int i = 0; i < 7; i++) begin
            send(seq[i]);
            if (i < 6) gap(3);
        end
        finish_in();
        nchecks++;
        if (wa_q.size() != 1) begin
            nerrors++;
            $display("FAIL framing_nwrites: got %0d expected 1", wa_q.size());
        end else begin
            nchecks++;
            if (wa_q[0] !== 12'h100 || wd_q[0] !== 8'hAA) begin
                nerrors++;
                $display("FAIL framing_write: %h=%h expected 100=aa", wa_q[0], wd_q[0]);
            end
        end
        nchecks++;
        if (done !== 1'b1) begin
            nerrors++;
            $display("FAIL framing_done: done=%b expected 1", done);
        end
    endtask

    task automatic test_restart();
        do_restart();
        send(8'hA5); send(8'h00); send(8'h04); send(8'h11);
        @(negedge clk);
        in_data  = 8'h22;
        in_valid = 1'b1;
        restart  = 1'b1;
        #1;
        nchecks++;
        if (in_ready !== 1'b0) begin
            nerrors++;
            $display("FAIL restart_block: in_ready=%b expected 0", in_ready);
        end
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        #1;
        nchecks++;
        if (wa_q.size() != 1 || mem_we !== 1'b0) begin
            nerrors++;
            $display("FAIL restart_writes: nwrites=%0d we=%b expected 1 0", wa_q.size(), mem_we);
        end else begin
            nchecks++;
            if (wa_q[0] !== 12'h100 || wd_q[0] !== 8'h11) begin
                nerrors++;
                $display("FAIL restart_inflight: %h=%h expected 100=11", wa_q[0], wd_q[0]);
            end
        end
        nchecks++;
        if ({cpu_hold, done, error, in_ready} !== 4'b1001) begin
            nerrors++;
            $display("FAIL restart_idle: hold=%b done=%b err=%b rdy=%b expected 1 0 0 1",
                     cpu_hold, done, error, in_ready);
        end
        clear_log();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h77); send(8'h77);
        finish_in();
        nchecks++;
        if (wa_q.size() != 1 || done !== 1'b1) begin
            nerrors++;
            $display("FAIL restart_reload: nwrites=%0d done=%b expected 1 1", wa_q.size(), done);
        end else begin
            nchecks++;
            if (wa_q[0] !== 12'h100 || wd_q[0] !== 8'h77) begin
                nerrors++;
                $display("FAIL restart_reload_write: %h=%h expected 100=77", wa_q[0], wd_q[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_restart();
        send(8'hA5); send(8'h00); send(8'h04); send(8'h11); send(8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nchecks++;
        if (mem_we !== 1'b1) begin
            nerrors++;
            $display("FAIL areset_pre_we: mem_we=%b expected 1", mem_we);
        end
        rst_n = 1'b0;
        #1;
        nchecks++;
        if ({mem_we, done, error, cpu_hold, mem_addr, mem_wdata} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00}) begin
            nerrors++;
            $display("FAIL areset_mid_data: we=%b done=%b err=%b hold=%b addr=%h wd=%h expected 0 0 0 1 000 00",
                     mem_we, done, error, cpu_hold, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        clear_log();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h5A); send(8'h5A);
        finish_in();
        nchecks++;
        if (done !== 1'b1 || wa_q.size() != 1) begin
            nerrors++;
            $display("FAIL areset_reload: done=%b nwrites=%0d expected 1 1", done, wa_q.size());
        end else begin
            nchecks++;
            if (wa_q[0] !== 12'h100 || wd_q[0] !== 8'h5A) begin
                nerrors++;
                $display("FAIL areset_reload_write: %h=%h expected 100=5a", wa_q[0], wd_q[0]);
            end
        end
        rst_n = 1'b0;
        #1;
        nchecks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL areset_from_done: done=%b hold=%b rdy=%b expected 0 1 1",
                     done, cpu_hold, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_csum();
        test_oversize();
        test_max_len_boundary();
        test_zero_len();
        test_framing_gaps();
        test_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
